// File: rtl/uart_tx_framer.sv
// UART transmit framer: start bit, DATA_BITS data bits LSB first, STOP_BITS stop bits.
// Define UART_TX_PARITY_EN to insert an even-parity bit between data and stop.
module uart_tx_framer #(
  parameter int CLKS_PER_BIT = 1,
  parameter int DATA_BITS    = 8,
  parameter int STOP_BITS    = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx_out,
  output logic       busy,
  output logic       done
);

  localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BAUD_W-1:0] BAUD_MAX = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [2:0] DATA_LAST = 3'(DATA_BITS - 1);
  localparam logic [2:0] STOP_LAST = 3'(STOP_BITS - 1);

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

  state_t             state_reg, state_next;
  logic [BAUD_W-1:0]  baud_reg, baud_next;
  logic [2:0]         bit_reg, bit_next;
  logic [7:0]         shift_reg, shift_next;
  logic               tx_out_reg, tx_out_next;
  logic               tx_ready_reg, tx_ready_next;
  logic               busy_reg, busy_next;
  logic               done_reg, done_next;
  logic               baud_wrap;
  logic [7:0]         data_masked;
`ifdef UART_TX_PARITY_EN
  logic               parity_reg, parity_next;
`endif

  // Bits above the frame width never reach the line or the parity.
  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_mask
      if (gi < DATA_BITS) begin : g_keep
        assign data_masked[gi] = tx_data[gi];
      end else begin : g_zero
        assign data_masked[gi] = 1'b0;
      end
    end
  endgenerate

  assign baud_wrap = (baud_reg == BAUD_MAX);

  always_comb begin
    state_next = state_reg;
    baud_next  = baud_reg;
    bit_next   = bit_reg;
    shift_next = shift_reg;
    done_next  = 1'b0;
`ifdef UART_TX_PARITY_EN
    parity_next = parity_reg;
`endif
    if (state_reg != IDLE) begin
      baud_next = baud_wrap ? '0 : baud_reg + 1'b1;
    end
    case (state_reg)
      IDLE: begin
        baud_next = '0;
        bit_next  = '0;
        if (tx_valid) begin
          state_next = START;
          shift_next = data_masked;
`ifdef UART_TX_PARITY_EN
          parity_next = ^data_masked;
`endif
        end
      end
      START: begin
        if (baud_wrap) state_next = DATA;
      end
      DATA: begin
        if (baud_wrap) begin
          shift_next = shift_reg >> 1;
          if (bit_reg == DATA_LAST) begin
            bit_next = '0;
`ifdef UART_TX_PARITY_EN
            state_next = PARITY;
`else
            state_next = STOP;
`endif
          end else begin
            bit_next = bit_reg + 3'd1;
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (baud_wrap) state_next = STOP;
      end
`endif
      STOP: begin
        if (baud_wrap) begin
          if (bit_reg == STOP_LAST) begin
            bit_next   = '0;
            state_next = IDLE;
            done_next  = 1'b1;
          end else begin
            bit_next = bit_reg + 3'd1;
          end
        end
      end
      default: state_next = IDLE;
    endcase

    // Line level is decoded from the upcoming state so tx_out leaves a flop.
    tx_out_next = 1'b1;
    case (state_next)
      START:  tx_out_next = 1'b0;
      DATA:   tx_out_next = shift_next[0];
`ifdef UART_TX_PARITY_EN
      PARITY: tx_out_next = parity_next;
`endif
      default: tx_out_next = 1'b1;
    endcase
    tx_ready_next = (state_next == IDLE);
    busy_next     = (state_next != IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= IDLE;
      baud_reg     <= '0;
      bit_reg      <= '0;
      shift_reg    <= '0;
      tx_out_reg   <= 1'b1;
      tx_ready_reg <= 1'b1;
      busy_reg     <= 1'b0;
      done_reg     <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_reg   <= 1'b0;
`endif
    end else begin
      state_reg    <= state_next;
      baud_reg     <= baud_next;
      bit_reg      <= bit_next;
      shift_reg    <= shift_next;
      tx_out_reg   <= tx_out_next;
      tx_ready_reg <= tx_ready_next;
      busy_reg     <= busy_next;
      done_reg     <= done_next;
`ifdef UART_TX_PARITY_EN
      parity_reg   <= parity_next;
`endif
    end
  end

  assign tx_out   = tx_out_reg;
  assign tx_ready = tx_ready_reg;
  assign busy     = busy_reg;
  assign done     = done_reg;

endmodule
